pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Parametrised hazard, forwarding and run-control unit for the 5-stage 16-bit pipelined processor (IF/ID/EX/MEM/WB). It generalises the current hazard logic in four ways: a configurable number of forwarding stages, a multi-cycle load-use bubble, data-memory wait states via a ready handshake, and a start/drain/halt sequencer. It also keeps a saturating stall-cycle counter. It sits beside the stage modules and drives their stall/flush inputs and the EX operand-select muxes.

Parameters:
REG_WIDTH, 4, register-address width.
FWD_STAGES, 2, number of downstream write-back sources that can forward (1..3); stage 1 is nearest to EX (EX/MEM).
LOAD_USE_STALL, 1, bubble cycles inserted per load-use hazard (1..3).
DRAIN_DEPTH, 3, cycles spent draining the pipe after a stop instruction (1..7).
SRC_W, $clog2(FWD_STAGES+1), width of operand-select codes (derived, not overridable).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  launch execution; honoured in IDLE or HALT.
stop_req  in  1  stop instruction decoded in ID.
rsD, rtD  in  REG_WIDTH each  ID source registers.
srcD_valid  in  2  bit0 = rsD used, bit1 = rtD used.
rsE, rtE  in  REG_WIDTH each  EX source registers.
MemReadE  in  1  load in EX.
WriteRegE  in  REG_WIDTH  load destination in EX.
wr_en_vec  in  FWD_STAGES  RegWrite of forwarding stage k (bit k-1).
wr_reg_vec  in  FWD_STAGES*REG_WIDTH  destination of stage k (slice k-1).
redirect  in  1  taken branch or jump resolved in MEM.
dm_req  in  1  DM access in MEM.
dm_ready  in  1  DM completes the access this cycle.
alu_src1, alu_src2  out  SRC_W each  0 = register file, k = forwarding stage k.
pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall  out  1 each  hold the register.
flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  load a bubble.
running  out  1  state is RUN or DRAIN.
stopped  out  1  state is HALT.
stall_cycles  out  16  count of stall cycles.

Behaviour:
- Reset: async entry to IDLE. Outputs at reset: alu_src* = 0, pc_stall = if_id_stall = 1, all other stalls/flushes = 0, running = stopped = 0, stall_cycles = 0, internal counters = 0.

FSM:
- IDLE: pc_stall and if_id_stall = 1. start → RUN.
- RUN: hazard logic active. stop_req (when no mem-wait) → DRAIN, with the drain counter loaded to DRAIN_DEPTH.
- DRAIN: pc_stall = 1 and flush_if_id = 1 every cycle. The counter decrements each non-wait cycle; at 1 → HALT. stop_req is ignored.
- HALT: all five stalls = 1, stopped = 1. start → RUN; the PC resumes where held.

Forwarding (combinational, all states):
- For each EX source, pick the lowest k with wr_en_vec[k-1] = 1 and wr_reg_vec slice equal to the source; if none, select 0.
- The nearest stage wins. Register 0 forwards like any other register (there is no hardwired zero register).

RUN hazard priority (highest first):
1. Mem-wait (dm_req & !dm_ready): all five stalls = 1, no flush. The load-use counter and drain counter are frozen.
2. Redirect: flush_if_id = flush_id_ex = flush_ex_mem = 1, no stall. The load-use counter is cleared.
3. Load-use: MemReadE and WriteRegE equal to a valid rsD/rtD → pc_stall = if_id_stall = flush_id_ex = 1, and the counter is loaded to LOAD_USE_STALL-1. While the counter is nonzero, the same bubble outputs repeat and the counter decrements.
4. Otherwise: no stall, no flush.

In DRAIN, rules 1 and 2 still apply (OR-ed with the drain outputs); rule 3 is suppressed.

stall_cycles:
- Increments on every RUN/DRAIN cycle in which pc_stall = 1.
- Saturates at 16'hFFFF.
- Cleared only by rst.

Latency:
- Stall, flush and forwarding outputs are same-cycle combinational from inputs plus state.
- State and counters update on the clock edge.

Test Plan:
- Forwarding: rst, start; rsE = 3 with stage1 and stage2 both writing r3 → alu_src1 = 1. Stage1 wr_en dropped → alu_src1 = 2. Neither stage writing r3 → alu_src1 = 0.
- Load-use: LOAD_USE_STALL = 2, MemReadE = 1, WriteRegE = 5, rtD = 5, srcD_valid = 2'b10 → pc_stall, if_id_stall and flush_id_ex high for exactly 2 cycles; stall_cycles = 2.
- Mem wait: dm_req = 1 with dm_ready low for 3 cycles → all five stalls = 1 for 3 cycles and no flush; resumes the cycle after dm_ready = 1.
- Redirect over load-use: redirect = 1 in the same cycle as a load-use hazard → three flushes = 1, no stall; the counter is cleared, so no bubble follows.
- Stop: stop_req pulse in RUN, DRAIN_DEPTH = 3 → 3 DRAIN cycles with flush_if_id = 1, then stopped = 1 and all stalls = 1. A subsequent start → RUN with running = 1.
- Async reset: assert rst mid-DRAIN, between clock edges → outputs immediately at reset values; after release the unit waits in IDLE for start.

Source files
------------

// File: rtl/pipe_hazard_if.sv
// Hazard-unit bundle: operand/hazard status from the pipeline stages and the
// stall/flush/forward controls returned to them.
interface pipe_hazard_if #(
    parameter int REG_WIDTH  = 4,
    parameter int FWD_STAGES = 2
);
    localparam int SRC_W = $clog2(FWD_STAGES + 1);

    logic                            start;
    logic                            stop_req;
    logic [REG_WIDTH-1:0]            rsD;
    logic [REG_WIDTH-1:0]            rtD;
    logic [1:0]                      srcD_valid;
    logic [REG_WIDTH-1:0]            rsE;
    logic [REG_WIDTH-1:0]            rtE;
    logic                            MemReadE;
    logic [REG_WIDTH-1:0]            WriteRegE;
    logic [FWD_STAGES-1:0]           wr_en_vec;
    logic [FWD_STAGES*REG_WIDTH-1:0] wr_reg_vec;
    logic                            redirect;
    logic                            dm_req;
    logic                            dm_ready;

    logic [SRC_W-1:0]                alu_src1;
    logic [SRC_W-1:0]                alu_src2;
    logic                            pc_stall;
    logic                            if_id_stall;
    logic                            id_ex_stall;
    logic                            ex_mem_stall;
    logic                            mem_wb_stall;
    logic                            flush_if_id;
    logic                            flush_id_ex;
    logic                            flush_ex_mem;
    logic                            running;
    logic                            stopped;
    logic [15:0]                     stall_cycles;

    modport master (
        output start, stop_req, rsD, rtD, srcD_valid, rsE, rtE, MemReadE, WriteRegE,
               wr_en_vec, wr_reg_vec, redirect, dm_req, dm_ready,
        input  alu_src1, alu_src2, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
               mem_wb_stall, flush_if_id, flush_id_ex, flush_ex_mem, running, stopped,
               stall_cycles
    );

    modport slave (
        input  start, stop_req, rsD, rtD, srcD_valid, rsE, rtE, MemReadE, WriteRegE,
               wr_en_vec, wr_reg_vec, redirect, dm_req, dm_ready,
        output alu_src1, alu_src2, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
               mem_wb_stall, flush_if_id, flush_id_ex, flush_ex_mem, running, stopped,
               stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and run-control unit for the 5-stage pipeline: operand
// forwarding, load-use bubbles, DM wait states and a start/drain/halt sequencer.
module pipe_hazard_ctrl #(
    parameter int REG_WIDTH      = 4,
    parameter int FWD_STAGES     = 2,
    parameter int LOAD_USE_STALL = 1,
    parameter int DRAIN_DEPTH    = 3
) (
    input logic         clk,
    input logic         rst,
    pipe_hazard_if.slave hz
);
    localparam int SRC_W = $clog2(FWD_STAGES + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} state_t;

    state_t      state, state_n;
    logic [1:0]  lu_cnt, lu_cnt_n;
    logic [2:0]  drain_cnt, drain_cnt_n;
    logic [15:0] stall_cnt;

    logic mem_wait, lu_hazard;
    logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
    logic flush_if_id, flush_id_ex, flush_ex_mem;

    assign mem_wait  = hz.dm_req & ~hz.dm_ready;
    assign lu_hazard = hz.MemReadE &
                       ((hz.srcD_valid[0] & (hz.WriteRegE == hz.rsD)) |
                        (hz.srcD_valid[1] & (hz.WriteRegE == hz.rtD)));

    // Scan farthest-to-nearest so the nearest matching stage overwrites the rest.
    always_comb begin
        hz.alu_src1 = '0;
        hz.alu_src2 = '0;
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (hz.wr_en_vec[k-1] && hz.wr_reg_vec[(k-1)*REG_WIDTH +: REG_WIDTH] == hz.rsE)
                hz.alu_src1 = SRC_W'(k);
            if (hz.wr_en_vec[k-1] && hz.wr_reg_vec[(k-1)*REG_WIDTH +: REG_WIDTH] == hz.rtE)
                hz.alu_src2 = SRC_W'(k);
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_n      = state;
        lu_cnt_n     = '0;
        drain_cnt_n  = drain_cnt;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_stall = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        hz.stopped   = 1'b0;

        unique case (state)
            IDLE: begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                if (hz.start) state_n = RUN;
            end
            RUN: begin
                if (mem_wait) begin
                    {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall} = '1;
                    lu_cnt_n = lu_cnt;
                end else if (hz.redirect) begin
                    {flush_if_id, flush_id_ex, flush_ex_mem} = '1;
                end else if (lu_cnt != 2'd0) begin
                    {pc_stall, if_id_stall, flush_id_ex} = '1;
                    lu_cnt_n = lu_cnt - 2'd1;
                end else if (lu_hazard) begin
                    {pc_stall, if_id_stall, flush_id_ex} = '1;
                    lu_cnt_n = 2'(LOAD_USE_STALL - 1);
                end
                if (hz.stop_req && !mem_wait) begin
                    state_n     = DRAIN;
                    drain_cnt_n = 3'(DRAIN_DEPTH);
                end
            end
            DRAIN: begin
                pc_stall    = 1'b1;
                flush_if_id = 1'b1;
                if (mem_wait) begin
                    {if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall} = '1;
                end else begin
                    if (hz.redirect) {flush_id_ex, flush_ex_mem} = '1;
                    if (drain_cnt <= 3'd1) begin
                        state_n     = HALT;
                        drain_cnt_n = '0;
                    end else begin
                        drain_cnt_n = drain_cnt - 3'd1;
                    end
                end
            end
            HALT: begin
                {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall} = '1;
                hz.stopped = 1'b1;
                if (hz.start) state_n = RUN;
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lu_cnt    <= '0;
            drain_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_n;
            lu_cnt    <= lu_cnt_n;
            drain_cnt <= drain_cnt_n;
            if ((state == RUN || state == DRAIN) && pc_stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign hz.pc_stall     = pc_stall;
    assign hz.if_id_stall  = if_id_stall;
    assign hz.id_ex_stall  = id_ex_stall;
    assign hz.ex_mem_stall = ex_mem_stall;
    assign hz.mem_wb_stall = mem_wb_stall;
    assign hz.flush_if_id  = flush_if_id;
    assign hz.flush_id_ex  = flush_id_ex;
    assign hz.flush_ex_mem = flush_ex_mem;
    assign hz.running      = (state == RUN) || (state == DRAIN);
    assign hz.stall_cycles = stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl (FWD_STAGES=2, LOAD_USE_STALL=2, DRAIN_DEPTH=3).
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_if #(.REG_WIDTH(4), .FWD_STAGES(2)) hz ();

    pipe_hazard_ctrl #(
        .REG_WIDTH(4), .FWD_STAGES(2), .LOAD_USE_STALL(2), .DRAIN_DEPTH(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] stalls();
        return {hz.pc_stall, hz.if_id_stall, hz.id_ex_stall, hz.ex_mem_stall, hz.mem_wb_stall};
    endfunction

    function automatic logic [2:0] flushes();
        return {hz.flush_if_id, hz.flush_id_ex, hz.flush_ex_mem};
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        hz.start = 0; hz.stop_req = 0; hz.rsD = 0; hz.rtD = 0; hz.srcD_valid = 0;
        hz.rsE = 0; hz.rtE = 0; hz.MemReadE = 0; hz.WriteRegE = 0;
        hz.wr_en_vec = 0; hz.wr_reg_vec = 0; hz.redirect = 0; hz.dm_req = 0; hz.dm_ready = 0;

        #3;
        check("rst_stalls",  32'(stalls()),          32'b11000);
        check("rst_flushes", 32'(flushes()),         32'd0);
        check("rst_status",  32'({hz.running, hz.stopped}), 32'd0);
        check("rst_cnt",     32'(hz.stall_cycles),   32'd0);
        check("rst_src",     32'({hz.alu_src1, hz.alu_src2}), 32'd0);
        #9 rst = 1'b0;

        hz.start = 1; tick(); hz.start = 0;
        check("run_entry",   32'({hz.running, hz.stopped}), 32'b10);
        check("run_stalls",  32'(stalls()),          32'd0);

        // Forwarding: nearest stage wins, fall back to farther stage, then register file.
        hz.rsE = 4'd3; hz.wr_en_vec = 2'b11; hz.wr_reg_vec = {4'd3, 4'd3}; #1;
        check("fwd_both",    32'(hz.alu_src1), 32'd1);
        hz.wr_en_vec = 2'b10; #1;
        check("fwd_stage2",  32'(hz.alu_src1), 32'd2);
        hz.wr_en_vec = 2'b11; hz.wr_reg_vec = {4'd6, 4'd7}; hz.rtE = 4'd7; #1;
        check("fwd_none",    32'(hz.alu_src1), 32'd0);
        check("fwd_rt_s1",   32'(hz.alu_src2), 32'd1);
        hz.rsE = 4'd0; hz.wr_en_vec = 2'b10; hz.wr_reg_vec = {4'd0, 4'd9}; #1;
        check("fwd_r0",      32'(hz.alu_src1), 32'd2);
        hz.wr_en_vec = 0; hz.wr_reg_vec = 0; hz.rsE = 0; hz.rtE = 0;

        // Load-use: a match on an unused source must not stall.
        hz.MemReadE = 1; hz.WriteRegE = 4'd5; hz.rsD = 4'd5; hz.rtD = 4'd2; hz.srcD_valid = 2'b10; #1;
        check("lu_invalid",  32'(stalls()), 32'd0);
        hz.rsD = 4'd1; hz.rtD = 4'd5; #1;
        check("lu_bub1_st",  32'(stalls()),  32'b11000);
        check("lu_bub1_fl",  32'(flushes()), 32'b010);
        tick(); hz.MemReadE = 0; #1;
        check("lu_bub2_st",  32'(stalls()),  32'b11000);
        check("lu_bub2_fl",  32'(flushes()), 32'b010);
        tick();
        check("lu_done",     32'({stalls(), flushes()}), 32'd0);
        check("lu_cnt",      32'(hz.stall_cycles), 32'd2);
        hz.srcD_valid = 0;

        // DM wait states: three waiting cycles, then the completing cycle.
        hz.dm_req = 1; hz.dm_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("mw_st%0d", i), 32'(stalls()),  32'b11111);
            check($sformatf("mw_fl%0d", i), 32'(flushes()), 32'd0);
            tick();
        end
        hz.dm_ready = 1; #1;
        check("mw_ready",    32'(stalls()), 32'd0);
        tick(); hz.dm_req = 0; hz.dm_ready = 0;
        check("mw_cnt",      32'(hz.stall_cycles), 32'd5);

        // Redirect outranks a simultaneous load-use and clears the bubble counter.
        hz.MemReadE = 1; hz.WriteRegE = 4'd5; hz.rtD = 4'd5; hz.srcD_valid = 2'b10; hz.redirect = 1; #1;
        check("rd_fl",       32'(flushes()), 32'b111);
        check("rd_st",       32'(stalls()),  32'd0);
        tick(); hz.MemReadE = 0; hz.redirect = 0; #1;
        check("rd_nobub",    32'({stalls(), flushes()}), 32'd0);
        check("rd_cnt",      32'(hz.stall_cycles), 32'd5);
        hz.srcD_valid = 0;

        // Stop: three drain cycles (a repeated stop_req mid-drain is ignored), then HALT.
        hz.stop_req = 1; #1;
        check("stop_run",    32'({hz.running, hz.pc_stall}), 32'b10);
        tick(); hz.stop_req = 0;
        for (int i = 0; i < 3; i++) begin
            hz.stop_req = (i == 1); #1;
            check($sformatf("drain_st%0d", i), 32'(stalls()),  32'b10000);
            check($sformatf("drain_fl%0d", i), 32'(flushes()), 32'b100);
            check($sformatf("drain_rs%0d", i), 32'({hz.running, hz.stopped}), 32'b10);
            tick();
        end
        hz.stop_req = 0;
        check("halt_st",     32'(stalls()), 32'b11111);
        check("halt_status", 32'({hz.running, hz.stopped}), 32'b01);
        check("halt_cnt",    32'(hz.stall_cycles), 32'd8);
        tick();
        check("halt_hold",   32'(hz.stall_cycles), 32'd8);
        hz.start = 1; tick(); hz.start = 0;
        check("resume",      32'({hz.running, hz.stopped, hz.pc_stall}), 32'b100);

        // Async reset in the middle of DRAIN, between edges.
        hz.stop_req = 1; tick(); hz.stop_req = 0; tick();
        check("pre_rst_drain", 32'(hz.running), 32'd1);
        #2 rst = 1'b1; #1;
        check("arst_st",     32'(stalls()),  32'b11000);
        check("arst_fl",     32'(flushes()), 32'd0);
        check("arst_status", 32'({hz.running, hz.stopped}), 32'd0);
        check("arst_cnt",    32'(hz.stall_cycles), 32'd0);
        #2 rst = 1'b0;
        tick(); tick();
        check("idle_wait",   32'({hz.running, hz.stopped, hz.pc_stall}), 32'b001);
        hz.start = 1; tick(); hz.start = 0;
        check("restart",     32'(hz.running), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
